motor_drive_decoder: RTL and testbench

Receiving end of the 5-bit motor-command word (MC1/MC2) produced by the navigation direction control. One instance per motor channel. Decodes direction and power, ramps the applied duty cycle toward the commanded power (acceleration modulation), and forces ramp-down plus dead time before any direction reversal. Drives the H-bridge inputs with a glitch-free PWM.

---
 rtl/motor_drive_decoder_if.sv | 13 +
 rtl/motor_drive_decoder.sv | 159 +++++++++++++++
 tb/tb_motor_drive_decoder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/motor_drive_decoder_if.sv
// Motor-command channel: 5-bit command in, H-bridge drive and status out.
// The decoder takes the slave side; the command source or bench takes the master side.
interface motor_drive_decoder_if;
    logic [4:0] mc;
    logic       in_a;
    logic       in_b;
    logic [7:0] duty;
    logic [2:0] state;
    logic       busy;

    modport master (output mc, input in_a, in_b, duty, state, busy);
    modport slave  (input mc, output in_a, in_b, duty, state, busy);
endinterface

// File: rtl/motor_drive_decoder.sv
// Per-channel motor command decoder: ramps duty toward commanded power, forces ramp-down
// and dead time before reversal, drives a wrap-latched PWM. Command to STATE: 2 clocks.
module motor_drive_decoder #(
    parameter int RAMP_DIV    = 1024,
    parameter int RAMP_STEP   = 8,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    motor_drive_decoder_if.slave drv_io
);
    localparam int RCW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DCW = $clog2(DEAD_CYCLES + 1);
    localparam logic [RCW-1:0] RAMP_LAST = RCW'(RAMP_DIV - 1);
    localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEAD_CYCLES - 1);
    localparam logic [8:0]     STEP9     = 9'(RAMP_STEP);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN_FWD   = 3'd1,
        S_RUN_REV   = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_DEAD      = 3'd4
    } state_e;

    logic [4:0]     mc_q;
    state_e         state_q, state_d;
    logic           old_rev_q, old_rev_d;
    logic [DCW-1:0] dead_cnt_q, dead_cnt_d;
    logic [RCW-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [7:0]     duty_q, duty_d;
    logic [7:0]     pwm_cnt_q, pwm_cnt_d;
    logic [7:0]     pwm_duty_q, pwm_duty_d;
    logic           in_a_q, in_a_d;
    logic           in_b_q, in_b_d;

    logic           cmd_fwd, cmd_rev, tick;
    logic [2:0]     pwr;
    logic [7:0]     target;
    logic [8:0]     up9, dn9;

    assign cmd_fwd = (mc_q[1:0] == 2'b00);
    assign cmd_rev = (mc_q[1:0] == 2'b10);
    assign pwr     = mc_q[4:2];
    assign target  = {pwr, pwr, pwr[2:1]};
    assign tick    = (ramp_cnt_q == RAMP_LAST);

    assign ramp_cnt_d = tick ? '0 : ramp_cnt_q + RCW'(1);
    assign dead_cnt_d = (state_q == S_DEAD) ? dead_cnt_q + DCW'(1) : '0;
    assign pwm_cnt_d  = pwm_cnt_q + 8'd1;
    assign pwm_duty_d = (pwm_cnt_q == 8'hFF) ? duty_q : pwm_duty_q;

    // 9-bit so that overflow past 255 and underflow below 0 are both visible.
    assign up9 = {1'b0, duty_q} + STEP9;
    assign dn9 = {1'b0, duty_q} - STEP9;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_q       <= 5'b00001;
            state_q    <= S_IDLE;
            old_rev_q  <= 1'b0;
            dead_cnt_q <= '0;
            ramp_cnt_q <= '0;
            duty_q     <= 8'd0;
            pwm_cnt_q  <= 8'd0;
            pwm_duty_q <= 8'd0;
            in_a_q     <= 1'b0;
            in_b_q     <= 1'b0;
        end else begin
            mc_q       <= drv_io.mc;
            state_q    <= state_d;
            old_rev_q  <= old_rev_d;
            dead_cnt_q <= dead_cnt_d;
            ramp_cnt_q <= ramp_cnt_d;
            duty_q     <= duty_d;
            pwm_cnt_q  <= pwm_cnt_d;
            pwm_duty_q <= pwm_duty_d;
            in_a_q     <= in_a_d;
            in_b_q     <= in_b_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        old_rev_d = old_rev_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fwd)      state_d = S_RUN_FWD;
                else if (cmd_rev) state_d = S_RUN_REV;
            end
            S_RUN_FWD: begin
                if (!cmd_fwd) begin
                    state_d   = S_RAMP_DOWN;
                    old_rev_d = 1'b0;
                end
            end
            S_RUN_REV: begin
                if (!cmd_rev) begin
                    state_d   = S_RAMP_DOWN;
                    old_rev_d = 1'b1;
                end
            end
            S_RAMP_DOWN: begin
                // Returning to the old direction resumes from the current duty, no dead time.
                if (old_rev_q ? cmd_rev : cmd_fwd)
                    state_d = old_rev_q ? S_RUN_REV : S_RUN_FWD;
                else if (duty_q == 8'd0)
                    state_d = S_DEAD;
            end
            S_DEAD: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    if (cmd_fwd)      state_d = S_RUN_FWD;
                    else if (cmd_rev) state_d = S_RUN_REV;
                    else              state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        duty_d = duty_q;
        case (state_q)
            S_IDLE: duty_d = 8'd0;
            S_RUN_FWD, S_RUN_REV: begin
                if (tick) begin
                    if (duty_q < target)
                        duty_d = (up9 > {1'b0, target}) ? target : up9[7:0];
                    else if (duty_q > target)
                        duty_d = (dn9[8] || (dn9[7:0] < target)) ? target : dn9[7:0];
                end
            end
            S_RAMP_DOWN: begin
                if (tick) duty_d = dn9[8] ? 8'd0 : dn9[7:0];
            end
            default: duty_d = duty_q;
        endcase
    end

    // Bridge inputs are registered from next-state values so they track the current
    // state/PWM exactly, with no combinational glitches on the pins.
    always_comb begin
        logic pwm_on;
        logic drive_a;
        logic drive_b;
        pwm_on  = (pwm_cnt_d < pwm_duty_d);
        drive_a = (state_d == S_RUN_FWD) || ((state_d == S_RAMP_DOWN) && !old_rev_d);
        drive_b = (state_d == S_RUN_REV) || ((state_d == S_RAMP_DOWN) &&  old_rev_d);
        in_a_d  = pwm_on && drive_a;
        in_b_d  = pwm_on && drive_b;
    end

    assign drv_io.in_a  = in_a_q;
    assign drv_io.in_b  = in_b_q;
    assign drv_io.duty  = duty_q;
    assign drv_io.state = state_q;
    assign drv_io.busy  = (state_q == S_RAMP_DOWN) || (state_q == S_DEAD);

endmodule

// File: tb/tb_motor_drive_decoder.sv
// Directed bench for motor_drive_decoder with RAMP_DIV=4, RAMP_STEP=32, DEAD_CYCLES=3,
// followed by a random command soak with a bridge-exclusivity monitor.
module tb_motor_drive_decoder;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    motor_drive_decoder_if drv_if ();

    motor_drive_decoder #(
        .RAMP_DIV   (4),
        .RAMP_STEP  (32),
        .DEAD_CYCLES(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .drv_io(drv_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits for DUTY to change, checks the new value and optionally the clocks waited.
    task automatic wait_duty(input string tag, input int exp, input int gap_exp);
        logic [7:0] prev;
        int         cyc;
        prev = drv_if.duty;
        cyc  = 0;
        while ((drv_if.duty === prev) && (cyc < 200)) begin
            step(1);
            cyc++;
        end
        chk(tag, int'(drv_if.duty), exp);
        if (gap_exp > 0) chk({tag, "_gap"}, cyc, gap_exp);
    endtask

    task automatic wait_state(input string tag, input int exp, input int max_cyc);
        int cyc;
        cyc = 0;
        while ((int'(drv_if.state) != exp) && (cyc < max_cyc)) begin
            step(1);
            cyc++;
        end
        chk(tag, int'(drv_if.state), exp);
    endtask

    task automatic count_window(output int na, output int nb);
        na = 0;
        nb = 0;
        for (int i = 0; i < 256; i++) begin
            if (drv_if.in_a) na++;
            if (drv_if.in_b) nb++;
            step(1);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("excl_ab", int'(drv_if.in_a & drv_if.in_b), 0);
            if ((drv_if.state == 3'd0) || (drv_if.state == 3'd4))
                chk("quiet_ab", int'(drv_if.in_a | drv_if.in_b), 0);
        end
    end

    initial begin
        int up_seq [8];
        int dn_seq [8];
        int na, nb, dead_len, dead_bad, k;
        up_seq = '{32, 64, 96, 128, 160, 192, 224, 255};
        dn_seq = '{223, 191, 159, 127, 95, 63, 31, 0};

        // Reset and neutral idle
        drv_if.mc = 5'b00001;
        #2 rst_n = 1'b0;
        step(3);
        chk("rst_state", int'(drv_if.state), 0);
        chk("rst_duty",  int'(drv_if.duty),  0);
        chk("rst_ab",    int'({drv_if.in_a, drv_if.in_b}), 0);
        chk("rst_busy",  int'(drv_if.busy),  0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            chk("idle_hold", int'({drv_if.state, drv_if.duty, drv_if.in_a, drv_if.in_b}), 0);
        end

        // Forward full power
        drv_if.mc = 5'b11100;
        step(1);
        chk("lat_edge1", int'(drv_if.state), 0);
        step(1);
        chk("lat_edge2", int'(drv_if.state), 1);
        for (int i = 0; i < 8; i++) wait_duty("fwd_up", up_seq[i], (i == 0) ? 0 : 4);
        step(10);
        chk("fwd_hold", int'(drv_if.duty), 255);
        step(512);
        count_window(na, nb);
        chk("fwd_pwm_a", na, 255);
        chk("fwd_pwm_b", nb, 0);

        // Reversal: ramp down, dead time, reverse ramp
        drv_if.mc = 5'b11110;
        step(2);
        chk("rd_state", int'(drv_if.state), 3);
        chk("rd_busy",  int'(drv_if.busy),  1);
        for (int i = 0; i < 8; i++) wait_duty("rd_down", dn_seq[i], (i == 0) ? 0 : 4);
        wait_state("dead_enter", 4, 10);
        chk("dead_busy", int'(drv_if.busy), 1);
        dead_len = 0;
        dead_bad = 0;
        while ((drv_if.state == 3'd4) && (dead_len < 20)) begin
            if (drv_if.in_a || drv_if.in_b) dead_bad++;
            dead_len++;
            step(1);
        end
        chk("dead_len", dead_len, 3);
        chk("dead_outs", dead_bad, 0);
        chk("rev_state", int'(drv_if.state), 2);
        chk("rev_busy",  int'(drv_if.busy),  0);
        for (int i = 0; i < 8; i++) wait_duty("rev_up", up_seq[i], (i == 0) ? 0 : 4);
        step(512);
        count_window(na, nb);
        chk("rev_pwm_a", na, 0);
        chk("rev_pwm_b", nb, 255);

        // Back to forward, then abort a reversal at duty 128
        drv_if.mc = 5'b11100;
        wait_state("fwd_again", 1, 200);
        for (int i = 0; i < 4; i++) wait_duty("fwd2_up", up_seq[i], (i == 0) ? 0 : 4);
        drv_if.mc = 5'b11110;
        step(2);
        chk("abort_rd", int'(drv_if.state), 3);
        wait_duty("abort_96", 96, 2);
        wait_duty("abort_64", 64, 4);
        drv_if.mc = 5'b11100;
        step(1);
        chk("abort_lat", int'(drv_if.state), 3);
        step(1);
        chk("abort_resume", int'(drv_if.state), 1);
        wait_duty("resume_96", 96, 2);
        for (int i = 3; i < 8; i++) wait_duty("resume_up", up_seq[i], 4);
        chk("resume_state", int'(drv_if.state), 1);

        // Neutral to idle, then retarget mid-ramp with clamp
        drv_if.mc = 5'b00001;
        wait_state("to_idle", 0, 200);
        chk("idle_duty", int'(drv_if.duty), 0);
        drv_if.mc = 5'b11100;
        wait_state("fwd3", 1, 10);
        for (int i = 0; i < 3; i++) wait_duty("fwd3_up", up_seq[i], (i == 0) ? 0 : 4);
        drv_if.mc = 5'b01000;
        wait_duty("clamp73", 73, 4);
        step(40);
        chk("clamp_hold", int'(drv_if.duty), 73);
        chk("clamp_state", int'(drv_if.state), 1);

        // Reverse to duty 160, then asynchronous reset
        drv_if.mc = 5'b11110;
        wait_duty("rd73_1", 41, 0);
        wait_duty("rd73_2", 9, 4);
        wait_duty("rd73_3", 0, 4);
        wait_state("rev2", 2, 20);
        for (int i = 0; i < 5; i++) wait_duty("rev2_up", up_seq[i], (i == 0) ? 0 : 4);
        chk("pre_rst_state", int'(drv_if.state), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_b",     int'(drv_if.in_b),  0);
        chk("arst_a",     int'(drv_if.in_a),  0);
        chk("arst_duty",  int'(drv_if.duty),  0);
        chk("arst_state", int'(drv_if.state), 0);
        chk("arst_busy",  int'(drv_if.busy),  0);
        step(2);
        rst_n = 1'b1;

        // Random command soak; the negedge monitor checks the bridge pins
        for (int c = 0; c < 10000; c += k) begin
            drv_if.mc = 5'($urandom_range(0, 31));
            k = $urandom_range(1, 40);
            step(k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
